uart_boot_sequencer: RTL

- Sequences CPU start-up after a UART program download.
- Takes received UART bytes and packs them into 32-bit little-endian words.
- Writes each word into instruction memory at consecutive addresses.
- After CELL_NUMBERS words, releases the CPU core: holds core reset until then, then asserts run. Sits between the UART receiver and the instruction-memory write port inside the CPU/UART top level.

---
 rtl/uart_boot_sequencer_pkg.sv | 18 +
 rtl/uart_boot_sequencer_if.sv | 24 ++
 rtl/uart_boot_sequencer_word_packer.sv | 41 ++++
 rtl/uart_boot_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/uart_boot_sequencer_pkg.sv
// Shared types and constants for the UART boot sequencer.
package uart_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD       = 4;
    localparam int IDX_W                = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_CELL_NUMBERS = 64;
    localparam int DEFAULT_ADDR_W       = 8;

endpackage

// File: rtl/uart_boot_sequencer_if.sv
// UART byte stream in, instruction-memory write port and core control out.
interface uart_boot_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata, core_rst, cpu_run, load_err, word_cnt
    );

    modport slave (
        input  rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata, core_rst, cpu_run, load_err, word_cnt
    );
endinterface

// File: rtl/uart_boot_sequencer_word_packer.sv
// Packs UART bytes into 32-bit little-endian words; word_ready fires combinationally with the 4th byte.
module uart_word_packer
    import uart_boot_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx;
    logic [23:0]      low_bytes;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            low_bytes <= '0;
        end else if (en && byte_valid) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                case (idx)
                    2'd0:    low_bytes[7:0]   <= byte_data;
                    2'd1:    low_bytes[15:8]  <= byte_data;
                    default: low_bytes[23:16] <= byte_data;
                endcase
            end
        end
    end

    // Top byte bypasses the register so the write can start the next cycle.
    assign word_ready = en && byte_valid && (idx == LAST_IDX);
    assign word       = {byte_data, low_bytes};

endmodule

// File: rtl/uart_boot_sequencer.sv
// Loads CELL_NUMBERS words from UART into instruction memory, then releases the CPU core.
// Optional trailing XOR checksum byte enabled by `define UART_BOOT_CHECKSUM_EN.
module uart_boot_sequencer
    import uart_boot_sequencer_pkg::*;
#(
    parameter int CELL_NUMBERS = DEFAULT_CELL_NUMBERS,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_boot_sequencer_if.slave  bus
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(CELL_NUMBERS - 1);

    state_t            state;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              core_rst_q;
    logic              cpu_run_q;
    logic [ADDR_W:0]   word_cnt_q;

    logic              packer_en;
    logic              word_ready;
    logic [31:0]       word;

    assign packer_en = (state == IDLE) || (state == LOAD) || (state == WRITE);

    uart_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (packer_en),
        .byte_valid (bus.rx_valid),
        .byte_data  (bus.rx_data),
        .word_ready (word_ready),
        .word       (word)
    );

`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0] csum;
    logic       load_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (packer_en && bus.rx_valid) begin
            csum <= csum ^ bus.rx_data;
        end
    end

    assign bus.load_err = load_err_q;
`else
    assign bus.load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            cpu_run_q    <= 1'b0;
            word_cnt_q   <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
            load_err_q   <= 1'b0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) state <= LOAD;
                end
                LOAD: begin
                    if (word_ready) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        imem_wdata_q <= word;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
                    if (word_cnt_q == LAST_CNT) begin
`ifdef UART_BOOT_CHECKSUM_EN
                        state <= CHECK;
`else
                        state      <= RUN;
                        core_rst_q <= 1'b0;
                        cpu_run_q  <= 1'b1;
`endif
                    end else begin
                        state <= LOAD;
                    end
                end
`ifdef UART_BOOT_CHECKSUM_EN
                CHECK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == csum) begin
                            state      <= RUN;
                            core_rst_q <= 1'b0;
                            cpu_run_q  <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                RUN, ERROR: state <= state;
                default:    state <= IDLE;
            endcase
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.word_cnt   = word_cnt_q;

endmodule
